// File: rtl/arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package arb_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam logic [7:0] CNT_MAX = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // 0 = CPU data port, 1 = loader/debug port
   typedef logic req_idx_t;

   function automatic req_idx_t onehot_to_idx(input logic [1:0] grant);
      return grant[1] & ~grant[0];
   endfunction

endpackage

// File: rtl/arb_pick.sv
// Two-way priority pick: one-hot grant from req, ties broken by prio.
module arb_pick
   import arb_pkg::*;
(
   input  logic [1:0] req,
   input  req_idx_t   prio,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      if (req == 2'b11) grant = prio ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter, 3-cycle access (IDLE/ISSUE/RESP).
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default is fixed priority to port 0.
//
//   state | meaning
//   IDLE  | no access in flight; winner latched when any req is high
//   ISSUE | memory strobe driven from latched request
//   RESP  | memory data returned, ack pulsed to winner
module mem_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic [1:0]        req,
   input  logic [1:0]        we,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        ack,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic [7:0]        cnt0,
   output logic [7:0]        cnt1
);

   state_t     state, state_nxt;
   req_idx_t   win;
   logic       lat_we;
   logic [1:0] grant;
   req_idx_t   prio;
   logic       take;

   assign take = (state == IDLE) && (|req);

   arb_pick u_pick (
      .req   (req),
      .prio  (prio),
      .grant (grant)
   );

`ifdef ARB_ROUND_ROBIN_EN
   // prio names the requester that wins the next tie; reset gives it to port 0
   req_idx_t prio_q;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset)    prio_q <= 1'b0;
      else if (take) prio_q <= ~onehot_to_idx(grant);
   end

   assign prio = prio_q;
`else
   assign prio = 1'b0;
`endif

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      ack       = 2'b00;
      rdata     = '0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (|req) state_nxt = ISSUE;
         end
         ISSUE: begin
            mem_en    = 1'b1;
            mem_we    = lat_we;
            state_nxt = RESP;
         end
         RESP: begin
            ack       = win ? 2'b10 : 2'b01;
            rdata     = mem_rdata;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // mem_addr/mem_wdata are the latch registers themselves so they hold while idle
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         win       <= 1'b0;
         lat_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (take) begin
         win       <= onehot_to_idx(grant);
         lat_we    <= grant[1] ? we[1]  : we[0];
         mem_addr  <= grant[1] ? addr1  : addr0;
         mem_wdata <= grant[1] ? wdata1 : wdata0;
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         cnt0 <= 8'd0;
         cnt1 <= 8'd0;
      end else if (state == RESP) begin
         if (!win && cnt0 != CNT_MAX) cnt0 <= cnt0 + 8'd1;
         if (win && cnt1 != CNT_MAX)  cnt1 <= cnt1 + 8'd1;
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width in bits.
REQ-002 Parameter DATA_W, default 8, memory data width in bits; matches the CPU ALUResult width.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req[1:0]  input  2  access request; req[0] = CPU data port, req[1] = loader/debug port.
REQ-006 we[1:0]  input  2  per-requester write enable; sampled with req.
REQ-007 addr0, addr1  input  ADDR_W each  per-requester address.
REQ-008 wdata0, wdata1  input  DATA_W each  per-requester write data.
REQ-009 ack[1:0]  output  2  one-cycle completion pulse to the served requester.
REQ-010 rdata  output  DATA_W  read data; valid only while ack is high.
REQ-011 mem_en, mem_we  output  1 each  shared memory strobe and write enable.
REQ-012 mem_addr, mem_wdata  output  ADDR_W / DATA_W  shared memory address and write data.
REQ-013 mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_en.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 cnt0, cnt1  output  8 each  completed-access counters per requester.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-017 IDLE: if any req bit is high, the arbiter SHALL latch the winner index, its we, addr and wdata, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-018 ISSUE: mem_en = 1, with mem_we, mem_addr and mem_wdata driven from the latched values for exactly one cycle; next state is RESP.
REQ-019 RESP: rdata = mem_rdata, ack[winner] = 1 for one cycle, the winner's counter SHALL increment, and the next state is IDLE.
REQ-020 Latency: a request sampled in IDLE on edge N SHALL receive ack during cycle N+2; maximum throughput is one access per 3 cycles.
REQ-021 Requesters hold req stable until ack; the arbiter SHALL drop the request in the ack cycle. A req sampled high again in IDLE starts a new access.
REQ-022 A req deasserted after being latched SHALL NOT abort the access; it completes and acks.
REQ-023 A req deasserted before being sampled in IDLE SHALL be ignored.
REQ-024 When idle, mem_en, mem_we, ack and rdata SHALL be 0, and mem_addr/mem_wdata SHALL hold the last latched values.
REQ-025 Counters SHALL saturate at 255 and not wrap.
REQ-026 Only one ack bit SHALL ever be high at a time, and never outside RESP.

Reset
REQ-027 Asserting reset (low) in any state, including mid-access, SHALL force IDLE immediately.
REQ-028 Reset SHALL clear ack, mem_en, mem_we, busy, rdata, mem_addr, mem_wdata, cnt0, cnt1 and the priority pointer, with no ack issued for the aborted access.
REQ-029 After reset, requester 0 SHALL hold priority.

Configuration
REQ-030 Macro ARB_ROUND_ROBIN_EN: when defined, the winner on simultaneous requests SHALL be the requester not granted last. The pointer updates on each grant, and reset makes requester 1 "last granted".
REQ-031 Without ARB_ROUND_ROBIN_EN, fixed priority SHALL apply: requester 0 always wins ties, and no pointer register is present.

Structure
REQ-032 A shared package arb_pkg SHALL hold the state enum (IDLE, ISSUE, RESP), the requester-index type and the default ADDR_W/DATA_W constants.
REQ-033 The priority selection SHALL be a sub-module arb_pick: combinational, req[1:0] and pointer in, one-hot grant out.

Verification
REQ-034 Single read: reset released, req0=1, we0=0, addr0=0x10, memory[0x10]=0x5A -> mem_en in cycle 1 with mem_addr=0x10; ack[0] and rdata=0x5A in cycle 2; cnt0=1.
REQ-035 Write: req1=1, we1=1, addr1=0x20, wdata1=0x33 -> mem_we=1, mem_addr=0x20, mem_wdata=0x33 for one cycle; ack[1] one cycle later; a following read of 0x20 returns 0x33.
REQ-036 Contention: req=2'b11 held for 4 accesses -> with ARB_ROUND_ROBIN_EN ack order is 0,1,0,1; without it the order is 0,0,0,0 and cnt1 stays 0.
REQ-037 Reset mid-access: reset low during ISSUE -> all outputs 0 immediately; no ack; after release, req0 is served from IDLE with 2-cycle latency.
REQ-038 Saturation: 260 back-to-back req0 reads -> cnt0=255 and it stays 255; ack count observed = 260.
REQ-039 Early drop: req0 pulsed for one cycle while IDLE -> access completes and ack[0] pulses; req1 pulsed only during ISSUE -> ignored, cnt1 unchanged.
